bird_launch_sequencer: RTL and testbench
========================================

Name: bird_launch_sequencer

Overview:
Parametrised launch sequencer for NUM_BIRDS birds. It turns player fire presses (rising edges) into one-cycle, one-hot shoot pulses, issuing birds in order 0..NUM_BIRDS-1. It locks out new presses while a bird is in flight and during a cooldown, and tracks the remaining birds. It sits between the key-input logic and the per-bird motion modules; the game-level logic issues new_round to reload.

Parameters:
NUM_BIRDS, 4, number of birds per round; legal range 2..16.
COOLDOWN_CYCLES, 16, clocks spent in COOLDOWN after each flight ends; must be >= 1.
FLIGHT_TIMEOUT, 0, maximum clocks in FLIGHT before a forced exit; 0 disables the timeout.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
fire_the_bird  in  1  fire key level, synchronous to clk
new_round  in  1  synchronous reload and abort request, level-sampled
bird_done  in  NUM_BIRDS  per-bird "flight finished" flags
bird_shoot  out  NUM_BIRDS  one-hot, one-cycle launch pulse to each bird module
current_bird  out  $clog2(NUM_BIRDS)  index of the next or active bird
birds_left  out  $clog2(NUM_BIRDS+1)  birds not yet launched this round
in_flight  out  1  high while in FLIGHT
out_of_birds  out  1  high while in EMPTY

Behaviour:
- Reset is decided as: reset resetN, asynchronous, active-low; clock clk.
- Reset values:
  - state = IDLE
  - bird_shoot = 0
  - current_bird = 0
  - birds_left = NUM_BIRDS
  - in_flight = 0, out_of_birds = 0
  - timer = 0
  - fire_q = 1, so a key held through reset does not fire.
- Press detection: press = fire_the_bird & ~fire_q; fire_q <= fire_the_bird every clock.
  - Presses outside IDLE are dropped, not queued.
  - A key held from FLIGHT into IDLE does not fire; the player must release and press again.
- All outputs are registered. States: IDLE, FLIGHT, COOLDOWN, EMPTY.
- IDLE: on press, at the same edge:
  - bird_shoot <= one-hot(current_bird)
  - birds_left <= birds_left - 1
  - timer <= 0
  - state <= FLIGHT
  - The pulse is visible for exactly the first FLIGHT cycle; latency is 1 clock from the press edge.
- FLIGHT:
  - bird_shoot <= 0 after that first cycle; in_flight = 1.
  - Exit to COOLDOWN when bird_done[current_bird] = 1, sampled from the second FLIGHT cycle onward.
  - Also exit to COOLDOWN when FLIGHT_TIMEOUT != 0 and timer reaches FLIGHT_TIMEOUT-1 (forced exit).
  - On exit, timer <= COOLDOWN_CYCLES-1.
  - bird_done bits of other birds are ignored.
- COOLDOWN: timer decrements each clock. When timer == 0, at the same edge:
  - current_bird <= current_bird + 1, wrapping to 0 after NUM_BIRDS-1.
  - state <= EMPTY if birds_left == 0, else IDLE.
  - COOLDOWN therefore lasts exactly COOLDOWN_CYCLES clocks.
- EMPTY: out_of_birds = 1; presses are ignored; the block waits for new_round.
- new_round = 1 in any state overrides everything at that edge:
  - state <= IDLE, bird_shoot <= 0, current_bird <= 0, birds_left <= NUM_BIRDS, timer <= 0.
  - new_round wins over a simultaneous press; that press is lost.
  - Held new_round keeps the block in IDLE with no launch.
- Simultaneous bird_done and timeout in FLIGHT: treated as one exit.
- Width rules:
  - The timer is wide enough for max(COOLDOWN_CYCLES, FLIGHT_TIMEOUT).
  - birds_left never underflows, because a launch only happens from IDLE, which requires birds_left >= 1.
- Reset asserted mid-flight returns to the reset values immediately; any bird_shoot pulse in progress is cut.

Test Plan:
Bench parameters: NUM_BIRDS=3, COOLDOWN_CYCLES=4, FLIGHT_TIMEOUT=20.
1. Reset, then one press, then bird_done[0] 5 clocks later -> bird_shoot=3'b001 for 1 clk one clock after the press edge; birds_left=2; in_flight high 5 clks; COOLDOWN 4 clks; back to IDLE with current_bird=1.
2. Three full launch cycles -> bird_shoot sequence 001, 010, 100; birds_left 2,1,0; after the third cooldown state=EMPTY, out_of_birds=1; a further press gives no pulse.
3. Fire held high for 50 clks from IDLE, plus extra presses during FLIGHT and COOLDOWN -> exactly one launch; after cooldown a new rising edge is required for the next launch.
4. No bird_done after launch -> forced exit after 20 FLIGHT clks, cooldown 4 clks, then current_bird advances; a bird_done[2] pulse while bird 0 flies is ignored.
5. new_round asserted mid-FLIGHT and also the same clock as a press in IDLE -> IDLE, birds_left=3, current_bird=0, no bird_shoot pulse; the next press launches bird 0.
6. fire_the_bird high during and after resetN deassertion -> no launch until the key is released and pressed; resetN pulsed in COOLDOWN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/bird_launch_sequencer_if.sv
// ---------------------------------------------------------------------------
// bird_launch_sequencer_if
//   Groups the player/game-side signals of the bird launch sequencer.
//
//   fire_the_bird : fire key level, synchronous to clk
//   new_round     : synchronous reload / abort request (level)
//   bird_done     : per-bird "flight finished" flags
//   bird_shoot    : one-hot, one-cycle launch pulse per bird
//   current_bird  : index of the next or active bird
//   birds_left    : birds not yet launched this round
//   in_flight     : high while a bird is flying
//   out_of_birds  : high once the round is exhausted
//
//   master : the side that drives the key inputs and consumes the status
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface bird_launch_sequencer_if #(
  parameter int NUM_BIRDS = 4
);
  localparam int IDX_W = $clog2(NUM_BIRDS);
  localparam int CNT_W = $clog2(NUM_BIRDS + 1);

  logic                 fire_the_bird;
  logic                 new_round;
  logic [NUM_BIRDS-1:0] bird_done;
  logic [NUM_BIRDS-1:0] bird_shoot;
  logic [IDX_W-1:0]     current_bird;
  logic [CNT_W-1:0]     birds_left;
  logic                 in_flight;
  logic                 out_of_birds;

  modport master (
    output fire_the_bird, new_round, bird_done,
    input  bird_shoot, current_bird, birds_left, in_flight, out_of_birds
  );

  modport slave (
    input  fire_the_bird, new_round, bird_done,
    output bird_shoot, current_bird, birds_left, in_flight, out_of_birds
  );
endinterface

// File: rtl/bird_launch_sequencer.sv
// ---------------------------------------------------------------------------
// bird_launch_sequencer
//   Turns fire-key rising edges into one-cycle one-hot launch pulses, issuing
//   birds 0..NUM_BIRDS-1 in order. A launch is only accepted from IDLE; the
//   block then waits for the active bird to finish (or time out), spends
//   COOLDOWN_CYCLES clocks in COOLDOWN, and either returns to IDLE or, once
//   every bird is used, parks in EMPTY until new_round reloads it.
//
//   Ports:
//     clk    : system clock
//     resetN : asynchronous active-low reset
//     bus    : slave side of bird_launch_sequencer_if (key inputs, bird
//              flags, launch pulses and status outputs)
// ---------------------------------------------------------------------------
module bird_launch_sequencer #(
  parameter int NUM_BIRDS       = 4,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int FLIGHT_TIMEOUT  = 0
) (
  input  logic                     clk,
  input  logic                     resetN,
  bird_launch_sequencer_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_BIRDS);
  localparam int CNT_W = $clog2(NUM_BIRDS + 1);
  localparam int T_MAX = (COOLDOWN_CYCLES > FLIGHT_TIMEOUT) ? COOLDOWN_CYCLES : FLIGHT_TIMEOUT;
  localparam int TW    = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

  localparam logic [TW-1:0]        COOL_LAST = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0]        TO_LAST   = TW'((FLIGHT_TIMEOUT > 0) ? FLIGHT_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]     LAST_BIRD = IDX_W'(NUM_BIRDS - 1);
  localparam logic [CNT_W-1:0]     FULL_LOAD = CNT_W'(NUM_BIRDS);
  localparam logic [NUM_BIRDS-1:0] ONE_HOT0  = NUM_BIRDS'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2,
    EMPTY    = 2'd3
  } state_t;

  state_t               state_q;
  logic                 fire_q;
  logic [TW-1:0]        timer_q;
  logic [NUM_BIRDS-1:0] bird_shoot_q;
  logic [IDX_W-1:0]     current_bird_q;
  logic [CNT_W-1:0]     birds_left_q;
  logic                 in_flight_q;
  logic                 out_of_birds_q;

  logic press;
  logic done_hit;
  logic timeout_hit;

  assign press = bus.fire_the_bird & ~fire_q;

  // The launch pulse is only high during the first FLIGHT cycle, so a zero
  // pulse register marks "second FLIGHT cycle or later", which is when the
  // bird's done flag starts to count.
  assign done_hit    = (bird_shoot_q == '0) && bus.bird_done[current_bird_q];
  assign timeout_hit = (FLIGHT_TIMEOUT != 0) && (timer_q == TO_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      fire_q         <= 1'b1;  // a key held through reset must not fire
      timer_q        <= '0;
      bird_shoot_q   <= '0;
      current_bird_q <= '0;
      birds_left_q   <= FULL_LOAD;
      in_flight_q    <= 1'b0;
      out_of_birds_q <= 1'b0;
    end else begin
      fire_q       <= bus.fire_the_bird;
      bird_shoot_q <= '0;  // pulses last a single cycle
      if (bus.new_round) begin
        state_q        <= IDLE;
        timer_q        <= '0;
        current_bird_q <= '0;
        birds_left_q   <= FULL_LOAD;
        in_flight_q    <= 1'b0;
        out_of_birds_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (press) begin
              bird_shoot_q <= ONE_HOT0 << current_bird_q;
              birds_left_q <= birds_left_q - CNT_W'(1);
              timer_q      <= '0;
              state_q      <= FLIGHT;
              in_flight_q  <= 1'b1;
            end
          end
          FLIGHT: begin
            if (done_hit || timeout_hit) begin
              state_q     <= COOLDOWN;
              timer_q     <= COOL_LAST;
              in_flight_q <= 1'b0;
            end else if (FLIGHT_TIMEOUT != 0) begin
              timer_q <= timer_q + TW'(1);
            end
          end
          COOLDOWN: begin
            if (timer_q == '0) begin
              current_bird_q <= (current_bird_q == LAST_BIRD) ? '0 : current_bird_q + IDX_W'(1);
              if (birds_left_q == '0) begin
                state_q        <= EMPTY;
                out_of_birds_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          EMPTY: begin
            // Parked until new_round.
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.bird_shoot   = bird_shoot_q;
  assign bus.current_bird = current_bird_q;
  assign bus.birds_left   = birds_left_q;
  assign bus.in_flight    = in_flight_q;
  assign bus.out_of_birds = out_of_birds_q;

endmodule

// File: tb/tb_bird_launch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bird_launch_sequencer
//   Directed scenarios followed by a randomized phase. A behavioural model
//   tracks the round as "birds launched so far", "cycles since launch" and
//   "cooldown clocks remaining"; every output is derived from those counts
//   and compared against the DUT on each falling clock edge.
// ---------------------------------------------------------------------------
module tb_bird_launch_sequencer;
  localparam int NB = 3;
  localparam int CD = 4;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic resetN = 1'b1;

  always #5 clk = ~clk;

  bird_launch_sequencer_if #(.NUM_BIRDS(NB)) bus ();

  bird_launch_sequencer #(
    .NUM_BIRDS      (NB),
    .COOLDOWN_CYCLES(CD),
    .FLIGHT_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int flight_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_launched = 0;   // birds launched in this round
  int   m_age      = -1;  // cycles since launch while flying, -1 otherwise
  int   m_cool     = 0;   // cooldown clocks still to spend
  logic m_prev_fire = 1'b1;

  int   n_launched, n_age, n_cool;
  int   m_cur;
  logic m_active, m_press, m_exit;
  int   e_shoot, e_cur, e_left;
  logic e_flight, e_empty;

  always_comb begin
    m_active = (m_age >= 0) || (m_cool > 0);
    m_cur    = (m_launched - (m_active ? 1 : 0)) % NB;
    e_cur    = m_cur;
    e_shoot  = (m_age == 0) ? (1 << m_cur) : 0;
    e_left   = NB - m_launched;
    e_flight = (m_age >= 0);
    e_empty  = !m_active && (m_launched == NB);

    m_press    = bus.fire_the_bird && !m_prev_fire;
    m_exit     = 1'b0;
    n_launched = m_launched;
    n_age      = m_age;
    n_cool     = m_cool;
    if (bus.new_round) begin
      n_launched = 0;
      n_age      = -1;
      n_cool     = 0;
    end else if (m_age >= 0) begin
      m_exit = ((m_age >= 1) && bus.bird_done[m_cur]) || (m_age + 1 == TO);
      if (m_exit) begin
        n_age  = -1;
        n_cool = CD;
      end else begin
        n_age = m_age + 1;
      end
    end else if (m_cool > 0) begin
      n_cool = m_cool - 1;
    end else if (m_launched < NB && m_press) begin
      n_launched = m_launched + 1;
      n_age      = 0;
    end
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_launched  <= 0;
      m_age       <= -1;
      m_cool      <= 0;
      m_prev_fire <= 1'b1;
    end else begin
      m_launched  <= n_launched;
      m_age       <= n_age;
      m_cool      <= n_cool;
      m_prev_fire <= bus.fire_the_bird;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    #2;
    forever begin
      @(negedge clk);
      check("bird_shoot",   32'(bus.bird_shoot),   32'(e_shoot));
      check("current_bird", 32'(bus.current_bird), 32'(e_cur));
      check("birds_left",   32'(bus.birds_left),   32'(e_left));
      check("in_flight",    32'(bus.in_flight),    32'(e_flight));
      check("out_of_birds", 32'(bus.out_of_birds), 32'(e_empty));
      if (bus.bird_shoot != '0) pulses++;
      if (bus.in_flight) flight_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Rising edge on the key; returns on the falling edge right after the
  // press edge, where a launch pulse should be visible.
  task automatic press_key();
    @(negedge clk) bus.fire_the_bird = 1'b1;
    @(negedge clk) bus.fire_the_bird = 1'b0;
  endtask

  task automatic reload();
    @(negedge clk) bus.new_round = 1'b1;
    @(negedge clk) bus.new_round = 1'b0;
  endtask

  // Launch bird b, let it fly for 'flight' cycles (>=2), wait out cooldown.
  task automatic launch(input int b, input int flight, input logic [2:0] exp_shoot);
    press_key();
    check("launch_shoot", 32'(bus.bird_shoot), 32'(exp_shoot));
    tick(flight - 1);
    bus.bird_done[b] = 1'b1;
    tick(1);
    bus.bird_done = '0;
    tick(CD);
  endtask

  int p0, f0;

  initial begin
    bus.fire_the_bird = 1'b0;
    bus.new_round     = 1'b0;
    bus.bird_done     = '0;
    #1 resetN = 1'b0;
    tick(2);
    check("reset_left",  32'(bus.birds_left), 32'd3);
    check("reset_shoot", 32'(bus.bird_shoot), 32'd0);
    resetN = 1'b1;
    tick(2);

    // 1: single launch, done 5 clocks after the press edge
    f0 = flight_cnt;
    press_key();
    check("t1_shoot",  32'(bus.bird_shoot), 32'd1);
    check("t1_left",   32'(bus.birds_left), 32'd2);
    check("t1_flight", 32'(bus.in_flight),  32'd1);
    tick(1);
    check("t1_pulse_one_cycle", 32'(bus.bird_shoot), 32'd0);
    tick(3);
    bus.bird_done[0] = 1'b1;
    tick(1);
    bus.bird_done = '0;
    check("t1_flight_len", 32'(flight_cnt - f0), 32'd5);
    tick(3);
    check("t1_cool_cur", 32'(bus.current_bird), 32'd0);
    tick(1);
    check("t1_next_cur", 32'(bus.current_bird), 32'd1);

    // 2: three full launches into EMPTY
    reload();
    launch(0, 3, 3'b001);
    check("t2_left0", 32'(bus.birds_left), 32'd2);
    launch(1, 2, 3'b010);
    check("t2_left1", 32'(bus.birds_left), 32'd1);
    launch(2, 4, 3'b100);
    check("t2_left2", 32'(bus.birds_left), 32'd0);
    check("t2_empty", 32'(bus.out_of_birds), 32'd1);
    p0 = pulses;
    press_key();
    tick(3);
    check("t2_no_pulse_empty", 32'(pulses - p0), 32'd0);

    // 3: held key gives one launch; presses in FLIGHT/COOLDOWN are dropped
    reload();
    p0 = pulses;
    @(negedge clk) bus.fire_the_bird = 1'b1;
    tick(4);
    bus.bird_done[0] = 1'b1;
    tick(1);
    bus.bird_done = '0;
    tick(45);
    bus.fire_the_bird = 1'b0;
    check("t3_held_one", 32'(pulses - p0), 32'd1);
    check("t3_left", 32'(bus.birds_left), 32'd2);
    tick(1);
    press_key();
    check("t3_shoot1", 32'(bus.bird_shoot), 32'd2);
    tick(1);
    press_key();
    tick(1);
    bus.bird_done[1] = 1'b1;
    tick(1);
    bus.bird_done = '0;
    press_key();
    tick(4);
    check("t3_pulses", 32'(pulses - p0), 32'd2);
    check("t3_cur", 32'(bus.current_bird), 32'd2);

    // 4: forced exit after 20 FLIGHT clocks; other bird's done ignored
    reload();
    f0 = flight_cnt;
    press_key();
    check("t4_shoot", 32'(bus.bird_shoot), 32'd1);
    tick(2);
    bus.bird_done[2] = 1'b1;
    tick(1);
    bus.bird_done = '0;
    tick(17);
    check("t4_flight_len", 32'(flight_cnt - f0), 32'd20);
    check("t4_exited", 32'(bus.in_flight), 32'd0);
    tick(3);
    check("t4_cool_cur", 32'(bus.current_bird), 32'd0);
    tick(1);
    check("t4_next_cur", 32'(bus.current_bird), 32'd1);

    // 5: new_round mid-flight, with a press, and held
    reload();
    press_key();
    tick(2);
    bus.new_round = 1'b1;
    tick(1);
    bus.new_round = 1'b0;
    check("t5_abort_flight", 32'(bus.in_flight),    32'd0);
    check("t5_abort_left",   32'(bus.birds_left),   32'd3);
    check("t5_abort_cur",    32'(bus.current_bird), 32'd0);
    p0 = pulses;
    @(negedge clk) begin bus.fire_the_bird = 1'b1; bus.new_round = 1'b1; end
    @(negedge clk) begin bus.fire_the_bird = 1'b0; bus.new_round = 1'b0; end
    tick(2);
    @(negedge clk) bus.new_round = 1'b1;
    press_key();
    press_key();
    @(negedge clk) bus.new_round = 1'b0;
    tick(1);
    check("t5_no_pulse", 32'(pulses - p0), 32'd0);
    check("t5_left", 32'(bus.birds_left), 32'd3);
    press_key();
    check("t5_shoot", 32'(bus.bird_shoot), 32'd1);

    // 6: key held across reset release; reset pulsed in COOLDOWN
    reload();
    p0 = pulses;
    @(negedge clk) bus.fire_the_bird = 1'b1;
    #2 resetN = 1'b0;
    tick(2);
    #2 resetN = 1'b1;
    tick(5);
    check("t6_held_reset", 32'(pulses - p0), 32'd0);
    @(negedge clk) bus.fire_the_bird = 1'b0;
    press_key();
    check("t6_shoot", 32'(bus.bird_shoot), 32'd1);
    tick(2);
    bus.bird_done[0] = 1'b1;
    tick(1);
    bus.bird_done = '0;
    tick(1);
    check("t6_pre_left", 32'(bus.birds_left), 32'd2);
    #2 resetN = 1'b0;
    #1;
    check("t6_async_left",   32'(bus.birds_left),   32'd3);
    check("t6_async_shoot",  32'(bus.bird_shoot),   32'd0);
    check("t6_async_flight", 32'(bus.in_flight),    32'd0);
    check("t6_async_empty",  32'(bus.out_of_birds), 32'd0);
    check("t6_async_cur",    32'(bus.current_bird), 32'd0);
    #3 resetN = 1'b1;
    tick(2);

    // randomized phase, checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bus.fire_the_bird = ~bus.fire_the_bird;
      bus.bird_done = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      bus.new_round = ($urandom_range(0, 96) == 0);
    end
    @(negedge clk) begin
      bus.fire_the_bird = 1'b0;
      bus.bird_done     = '0;
      bus.new_round     = 1'b0;
    end
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
